serial_sub_ctrl: RTL and testbench
==================================

SERIAL_SUB_CTRL -- requirements
Module: serial_sub_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: start  input  1  request to begin a subtraction; sampled only in IDLE.
REQ-005 Port: a_in  input  WIDTH  minuend; sampled at the edge where start is accepted.
REQ-006 Port: b_in  input  WIDTH  subtrahend; sampled at the edge where start is accepted.
REQ-007 Port: bin  input  1  borrow-in for bit 0; sampled at the edge where start is accepted.
REQ-008 Port: busy  output  1  high whenever state is not IDLE.
REQ-009 Port: done  output  1  one-cycle pulse; result valid.
REQ-010 Port: diff_out  output  WIDTH  registered result, a_in - b_in - bin modulo 2^WIDTH.
REQ-011 Port: bout  output  1  registered final borrow-out (1 when a_in < b_in + bin).

Function
REQ-012 The block shall compute one result bit per cycle through a single instance of the existing fullsubtractor cell (ports a, b, c, diff, br); no parallel subtractor shall be used.
REQ-013 States: IDLE, SHIFT, DONE; encoding is free.
REQ-014 IDLE: start=1 at an edge -> latch a_in, b_in into operand shift registers, latch bin into the borrow flop, clear the bit counter, go to SHIFT.
REQ-015 IDLE: start=0 -> remain in IDLE; outputs hold.
REQ-016 SHIFT: each cycle the cell receives operand bit 0 of each shift register and the borrow flop; at the edge, cell diff enters the result shift register MSB-side (LSB-first shifting), cell br loads the borrow flop, operands shift right by one, counter increments.
REQ-017 SHIFT: at the edge where counter = WIDTH-1, the final bit is processed, diff_out and bout load from the completed result and final borrow, state goes to DONE.
REQ-018 DONE: done=1 for exactly this one cycle; next edge -> IDLE unconditionally.
REQ-019 Latency: start accepted at edge k -> diff_out/bout update at edge k+WIDTH -> done high during cycle k+WIDTH to k+WIDTH+1 -> IDLE (busy=0) after edge k+WIDTH+1.
REQ-020 start asserted in SHIFT or DONE shall be ignored (not queued); a_in, b_in, bin changes while busy shall not affect the result.
REQ-021 Back-to-back: start held high continuously yields one operation every WIDTH+2 cycles.
REQ-022 diff_out and bout shall hold their last value from DONE until the next operation's update edge; they shall not change during SHIFT.
REQ-023 Borrow chain: borrow-in of bit i (i>0) shall be borrow-out of bit i-1; wrap-around modulo 2^WIDTH, bout reports the underflow.

Reset
REQ-024 rst=1 at an edge shall force IDLE, busy=0, done=0, diff_out=0, bout=0, counter=0, borrow flop=0, operand and result shift registers=0.
REQ-025 rst has priority over start and over any in-progress operation; an operation interrupted by rst shall produce no done pulse and no diff_out/bout update.
REQ-026 start sampled in the same cycle as rst=1 shall be ignored; the first acceptable start is at the first edge with rst=0.

Verification
REQ-027 WIDTH=8, a_in=0x05, b_in=0x03, bin=0, start pulse -> done 8 edges later, diff_out=0x02, bout=0.
REQ-028 a_in=0x03, b_in=0x05, bin=0 -> diff_out=0xFE, bout=1; a_in=0x00, b_in=0x00, bin=1 -> diff_out=0xFF, bout=1.
REQ-029 a_in=0xFF, b_in=0xFF, bin=1 -> diff_out=0xFF, bout=1; a_in=0xFF, b_in=0x00, bin=0 -> diff_out=0xFF, bout=0.
REQ-030 start pulsed again 3 cycles after acceptance with different operands -> ignored; result matches first operands; exactly one done pulse.
REQ-031 rst asserted 4 cycles into SHIFT -> next cycle busy=0, done=0, diff_out=0x00, bout=0; no done pulse follows; a new start then completes normally.
REQ-032 start held high for 30 cycles with fixed operands -> done pulses spaced exactly 10 cycles apart, busy low one cycle between operations; exhaustive 3-bit random compare against a_in-b_in-bin reference model with WIDTH=3.

Source files
------------

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor: a_in - b_in - bin, one bit per cycle, LSB first,
// using a single full-subtractor cell under a three-state controller.
module serial_sub_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff_out,
  output logic             bout
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             load_op;
  logic             step;
  logic             finish;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             borrow;
  logic [CNT_W-1:0] cnt;

  logic             cell_diff;
  logic             cell_br;

  fullsubtractor u_cell (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .c    (borrow),
    .diff (cell_diff),
    .br   (cell_br)
  );

  // Next-state and datapath strobes
  always_comb begin
    state_nxt = state;
    load_op   = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SHIFT;
          load_op   = 1'b1;
        end
      end
      SHIFT: begin
        step = 1'b1;
        if (cnt == LAST_BIT) begin
          finish    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register; busy/done registered from the upcoming state
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
      done  <= (state_nxt == DONE);
    end
  end

  // Operand/result shifting; outputs only move on the final bit
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr     <= '0;
      b_sr     <= '0;
      res_sr   <= '0;
      borrow   <= 1'b0;
      cnt      <= '0;
      diff_out <= '0;
      bout     <= 1'b0;
    end else begin
      if (load_op) begin
        a_sr   <= a_in;
        b_sr   <= b_in;
        borrow <= bin;
        cnt    <= '0;
      end else if (step) begin
        a_sr   <= a_sr >> 1;
        b_sr   <= b_sr >> 1;
        borrow <= cell_br;
        res_sr <= WIDTH'({cell_diff, res_sr} >> 1);
        cnt    <= cnt + CNT_W'(1);
      end
      if (finish) begin
        diff_out <= WIDTH'({cell_diff, res_sr} >> 1);
        bout     <= cell_br;
      end
    end
  end

endmodule

// One-bit full subtractor: diff = a - b - c, br = borrow out.
module fullsubtractor (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic diff,
  output logic br
);
  assign diff = a ^ b ^ c;
  assign br   = (~a & b) | (~(a ^ b) & c);
endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Bench for serial_sub_ctrl: directed table, multi-cycle corner sequences,
// and random/exhaustive runs against an arithmetic reference.
module tb_serial_sub_ctrl;

  logic       clk;
  logic       rst;

  logic       start8, c8, busy8, done8, bo8;
  logic [7:0] a8, b8, d8;

  logic       start3, c3, busy3, done3, bo3;
  logic [2:0] a3, b3, d3;

  int total = 0;
  int bad   = 0;

  serial_sub_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a_in(a8), .b_in(b8), .bin(c8),
    .busy(busy8), .done(done8), .diff_out(d8), .bout(bo8)
  );

  serial_sub_ctrl #(.WIDTH(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .a_in(a3), .b_in(b3), .bin(c3),
    .busy(busy3), .done(done3), .diff_out(d3), .bout(bo3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic [7:0] d;
    logic       bo;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  // Reference: plain integer subtraction, wrapped modulo 2^w; bit 32 = underflow
  function automatic logic [32:0] model(input int w, input longint a, input longint b, input longint c);
    longint m = longint'(1) << w;
    longint r = a - b - c;
    logic under = (r < 0);
    if (under) r = r + m;
    return {under, 32'(r)};
  endfunction

  // One full WIDTH=8 operation; inputs are scrambled while busy
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c,
                      output logic [7:0] d, output logic bo, output logic ok);
    logic [7:0] prev_d;
    logic       prev_b;
    ok = 1'b1;
    @(negedge clk);
    a8 = a; b8 = b; c8 = c; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    prev_d = d8; prev_b = bo8;
    if (!busy8 || done8) ok = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
      @(posedge clk); #1;
      if (i < 8 && (done8 || !busy8 || d8 !== prev_d || bo8 !== prev_b)) ok = 1'b0;
    end
    if (!done8 || !busy8) ok = 1'b0;
    d = d8; bo = bo8;
    @(posedge clk); #1;
    if (done8 || busy8) ok = 1'b0;
  endtask

  task automatic run3(input logic [2:0] a, input logic [2:0] b, input logic c,
                      output logic [2:0] d, output logic bo, output logic ok);
    ok = 1'b1;
    @(negedge clk);
    a3 = a; b3 = b; c3 = c; start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      a3 = 3'($urandom); b3 = 3'($urandom); c3 = 1'($urandom);
      @(posedge clk); #1;
      if (i < 3 && (done3 || !busy3)) ok = 1'b0;
    end
    if (!done3) ok = 1'b0;
    d = d3; bo = bo3;
    @(posedge clk); #1;
    if (done3 || busy3) ok = 1'b0;
  endtask

  initial begin
    vec_t        vecs[9];
    logic [7:0]  d;
    logic [2:0]  dd;
    logic        bo, ok;
    logic [32:0] m;
    int          ndone;
    int          dcyc[$];
    int          busy_low;

    rst = 1'b1; start8 = 1'b1; a8 = 8'h12; b8 = 8'h34; c8 = 1'b0;
    start3 = 1'b0; a3 = '0; b3 = '0; c3 = 1'b0;

    // Reset with start held: nothing may be accepted
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy8), 32'd0);
    check("rst_done", 32'(done8), 32'd0);
    check("rst_diff", 32'(d8), 32'd0);
    check("rst_bout", 32'(bo8), 32'd0);
    check("rst_busy3", 32'(busy3), 32'd0);

    // First edge with rst low accepts the held start
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("first_accept", 32'(busy8), 32'd1);
    start8 = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done8) begin ndone++; d = d8; bo = bo8; end
    end
    check("first_done_cnt", 32'(ndone), 32'd1);
    check("first_diff", 32'(d), 32'hDE);
    check("first_bout", 32'(bo), 32'd1);

    // Directed table
    vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0};
    vecs[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1};
    vecs[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[4] = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0};
    vecs[5] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0};
    vecs[6] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
    vecs[7] = '{8'h7F, 8'h7F, 1'b0, 8'h00, 1'b0};
    vecs[8] = '{8'h0A, 8'h0A, 1'b1, 8'hFF, 1'b1};
    for (int i = 0; i < 9; i++) begin
      run8(vecs[i].a, vecs[i].b, vecs[i].c, d, bo, ok);
      check($sformatf("vec%0d_timing", i), 32'(ok), 32'd1);
      check($sformatf("vec%0d_diff", i), 32'(d), 32'(vecs[i].d));
      check($sformatf("vec%0d_bout", i), 32'(bo), 32'(vecs[i].bo));
    end

    // Start re-pulsed mid-operation is ignored
    @(negedge clk);
    a8 = 8'h10; b8 = 8'h01; c8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    ndone = 0;
    for (int cy = 1; cy <= 20; cy++) begin
      @(posedge clk); #1;
      if (cy == 3) begin start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; c8 = 1'b1; end
      if (cy == 4) start8 = 1'b0;
      if (done8) begin ndone++; d = d8; bo = bo8; end
    end
    check("ignore_done_cnt", 32'(ndone), 32'd1);
    check("ignore_diff", 32'(d), 32'h0F);
    check("ignore_bout", 32'(bo), 32'd0);
    check("ignore_idle", 32'(busy8), 32'd0);

    // Reset 4 cycles into SHIFT aborts without update
    @(negedge clk);
    a8 = 8'h33; b8 = 8'h11; c8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", 32'(busy8), 32'd0);
    check("abort_done", 32'(done8), 32'd0);
    check("abort_diff", 32'(d8), 32'd0);
    check("abort_bout", 32'(bo8), 32'd0);
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (done8) ndone++;
    end
    check("abort_no_done", 32'(ndone), 32'd0);
    run8(8'h33, 8'h11, 1'b0, d, bo, ok);
    check("after_abort_timing", 32'(ok), 32'd1);
    check("after_abort_diff", 32'(d), 32'h22);

    // start held high: one operation per 10 cycles
    @(negedge clk);
    a8 = 8'h40; b8 = 8'h11; c8 = 1'b1; start8 = 1'b1;
    busy_low = 0;
    for (int cy = 0; cy < 42; cy++) begin
      @(posedge clk); #1;
      if (cy == 29) start8 = 1'b0;
      if (done8) begin
        dcyc.push_back(cy);
        check("b2b_diff", 32'(d8), 32'h2E);
      end
      if (!busy8 && cy < 29) busy_low++;
    end
    check("b2b_pulses", 32'(dcyc.size()), 32'd3);
    for (int i = 1; i < dcyc.size(); i++)
      check("b2b_spacing", 32'(dcyc[i] - dcyc[i-1]), 32'd10);
    check("b2b_busy_low", 32'(busy_low), 32'd2);

    // Random WIDTH=8 operations against the reference
    for (int n = 0; n < 150; n++) begin
      logic [7:0] ra, rb;
      logic       rc;
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      run8(ra, rb, rc, d, bo, ok);
      m = model(8, longint'(ra), longint'(rb), longint'(rc));
      check("rand8_timing", 32'(ok), 32'd1);
      check("rand8_diff", 32'(d), m[31:0]);
      check("rand8_bout", 32'(bo), 32'(m[32]));
    end

    // Exhaustive WIDTH=3, visited in a random starting rotation
    begin
      int base;
      base = int'($urandom_range(0, 127));
      for (int k = 0; k < 128; k++) begin
        int idx, ea, eb, ec;
        idx = (k + base) % 128;
        ea = idx / 16; eb = (idx / 2) % 8; ec = idx % 2;
        run3(3'(ea), 3'(eb), 1'(ec), dd, bo, ok);
        m = model(3, longint'(ea), longint'(eb), longint'(ec));
        check("ex3_timing", 32'(ok), 32'd1);
        check("ex3_diff", 32'(dd), m[31:0]);
        check("ex3_bout", 32'(bo), 32'(m[32]));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
